// File: rtl/oc4_vc3_cmd_arb_if.sv
// oc4_vc3_cmd_arb_if
// Bundles the AFU-side command/data requesters, the TLX credit returns and
// the VC3/DCP3 command path of the arbiter into one interface.
// The slave modport is the arbiter; the master modport is the surrounding
// environment (AFU sources plus TLX), which drives the arbiter inputs.
interface oc4_vc3_cmd_arb_if #(
   parameter int VC3_CW  = 4,
   parameter int DCP3_CW = 6
);
   // TLX credit initialisation and returns
   logic [3:0]          tlx_afu_vc3_initial_credit;
   logic [5:0]          tlx_afu_dcp3_initial_credit;
   logic                tlx_afu_vc3_credit;
   logic                tlx_afu_dcp3_credit;

   // Requester 0
   logic                req0_valid;
   logic [7:0]          req0_opcode;
   logic [15:0]         req0_afutag;
   logic [67:0]         req0_ea;
   logic [1:0]          req0_dl;
   logic                req0_wdata;
   logic                req0_ack;
   logic                req0_data_valid;
   logic [511:0]        req0_data_bus;
   logic                req0_data_ready;

   // Requester 1
   logic                req1_valid;
   logic [7:0]          req1_opcode;
   logic [15:0]         req1_afutag;
   logic [67:0]         req1_ea;
   logic [1:0]          req1_dl;
   logic                req1_wdata;
   logic                req1_ack;
   logic                req1_data_valid;
   logic [511:0]        req1_data_bus;
   logic                req1_data_ready;

   // VC3 command and DCP3 data towards TLX
   logic                afu_tlx_vc3_valid;
   logic [7:0]          afu_tlx_vc3_opcode;
   logic [15:0]         afu_tlx_vc3_afutag;
   logic [67:0]         afu_tlx_vc3_ea_ta_or_obj;
   logic [1:0]          afu_tlx_vc3_dl;
   logic                afu_tlx_dcp3_data_valid;
   logic [511:0]        afu_tlx_dcp3_data_bus;
   logic                afu_tlx_dcp3_data_bdi;

   // Status
   logic [VC3_CW-1:0]   vc3_credit_cnt;
   logic [DCP3_CW-1:0]  dcp3_credit_cnt;
   logic                credit_err;
   logic [15:0]         req0_cmd_count;
   logic [15:0]         req1_cmd_count;

   modport slave (
      input  tlx_afu_vc3_initial_credit, tlx_afu_dcp3_initial_credit,
      input  tlx_afu_vc3_credit, tlx_afu_dcp3_credit,
      input  req0_valid, req0_opcode, req0_afutag, req0_ea, req0_dl, req0_wdata,
      input  req0_data_valid, req0_data_bus,
      input  req1_valid, req1_opcode, req1_afutag, req1_ea, req1_dl, req1_wdata,
      input  req1_data_valid, req1_data_bus,
      output req0_ack, req0_data_ready, req1_ack, req1_data_ready,
      output afu_tlx_vc3_valid, afu_tlx_vc3_opcode, afu_tlx_vc3_afutag,
      output afu_tlx_vc3_ea_ta_or_obj, afu_tlx_vc3_dl,
      output afu_tlx_dcp3_data_valid, afu_tlx_dcp3_data_bus, afu_tlx_dcp3_data_bdi,
      output vc3_credit_cnt, dcp3_credit_cnt, credit_err,
      output req0_cmd_count, req1_cmd_count
   );

   modport master (
      output tlx_afu_vc3_initial_credit, tlx_afu_dcp3_initial_credit,
      output tlx_afu_vc3_credit, tlx_afu_dcp3_credit,
      output req0_valid, req0_opcode, req0_afutag, req0_ea, req0_dl, req0_wdata,
      output req0_data_valid, req0_data_bus,
      output req1_valid, req1_opcode, req1_afutag, req1_ea, req1_dl, req1_wdata,
      output req1_data_valid, req1_data_bus,
      input  req0_ack, req0_data_ready, req1_ack, req1_data_ready,
      input  afu_tlx_vc3_valid, afu_tlx_vc3_opcode, afu_tlx_vc3_afutag,
      input  afu_tlx_vc3_ea_ta_or_obj, afu_tlx_vc3_dl,
      input  afu_tlx_dcp3_data_valid, afu_tlx_dcp3_data_bus, afu_tlx_dcp3_data_bdi,
      input  vc3_credit_cnt, dcp3_credit_cnt, credit_err,
      input  req0_cmd_count, req1_cmd_count
   );
endinterface

// File: rtl/oc4_vc3_cmd_arb.sv
// oc4_vc3_cmd_arb
// Round-robin arbiter for two AFU command requesters onto the OCSE4 VC3
// command path, with write-data flit sequencing onto DCP3. A command is only
// issued when one VC3 credit and enough DCP3 credits for its flits are held.
// Optional feature macro: OC4_VC3_ARB_STATS_EN builds per-requester
// issued-command counters; without it the counters read as zero.
module oc4_vc3_cmd_arb #(
   parameter int VC3_CW  = 4,
   parameter int DCP3_CW = 6
) (
   input  logic              clock,
   input  logic              reset,
   oc4_vc3_cmd_arb_if.slave  bus
);

   typedef enum logic [1:0] {INIT, IDLE, DATA} state_t;

   state_t               state_q;
   logic                 rrPtr_q;
   logic                 sel_q;
   logic [2:0]           flitCnt_q;
   logic [VC3_CW-1:0]    vc3Cnt_q, vc3Cnt_d;
   logic [DCP3_CW-1:0]   dcp3Cnt_q, dcp3Cnt_d;
   logic                 creditErr_q, creditErr_d;

   logic                 vc3Valid_q;
   logic [7:0]           vc3Opcode_q;
   logic [15:0]          vc3Afutag_q;
   logic [67:0]          vc3Ea_q;
   logic [1:0]           vc3Dl_q;
   logic                 dcp3Valid_q;
   logic [511:0]         dcp3Bus_q;

   logic [2:0]           cost0, cost1, grantCost;
   logic                 elig0, elig1, grant0, grant1, grant, grantId;
   logic                 ready0, ready1, flitAccept;
   logic [511:0]         selBus;
   logic [VC3_CW:0]      vc3Sum;
   logic [DCP3_CW:0]     dcp3Sum;

   // Number of DCP3 flits a command will need; zero for commands without data
   function automatic logic [2:0] flitCost(input logic wdata, input logic [1:0] dl);
      logic [2:0] cost;
      cost = 3'd0;
      if (wdata) begin
         case (dl)
            2'b10:   cost = 3'd2;
            2'b11:   cost = 3'd4;
            default: cost = 3'd1;
         endcase
      end
      return cost;
   endfunction

   // Eligibility and round-robin grant; the pointer's requester wins ties,
   // and an ineligible requester never holds off the other one
   always_comb begin
      cost0     = flitCost(bus.req0_wdata, bus.req0_dl);
      cost1     = flitCost(bus.req1_wdata, bus.req1_dl);
      elig0     = bus.req0_valid && (vc3Cnt_q != '0) && (dcp3Cnt_q >= DCP3_CW'(cost0));
      elig1     = bus.req1_valid && (vc3Cnt_q != '0) && (dcp3Cnt_q >= DCP3_CW'(cost1));
      grant0    = (state_q == IDLE) && elig0 && (!rrPtr_q || !elig1);
      grant1    = (state_q == IDLE) && elig1 && (rrPtr_q || !elig0);
      grant     = grant0 || grant1;
      grantId   = grant1;
      grantCost = grant1 ? cost1 : (grant0 ? cost0 : 3'd0);
   end

   // Data-phase handshake: only the requester owning the current write is ready
   always_comb begin
      ready0     = (state_q == DATA) && !sel_q;
      ready1     = (state_q == DATA) && sel_q;
      flitAccept = (ready0 && bus.req0_data_valid) || (ready1 && bus.req1_data_valid);
      selBus     = sel_q ? bus.req1_data_bus : bus.req0_data_bus;
   end

   // Credit bookkeeping: returns and consumes in the same cycle net out, and a
   // return that would exceed the counter range saturates and flags an error
   always_comb begin
      vc3Sum      = {1'b0, vc3Cnt_q} + {{VC3_CW{1'b0}}, bus.tlx_afu_vc3_credit}
                    - {{VC3_CW{1'b0}}, grant};
      dcp3Sum     = {1'b0, dcp3Cnt_q} + {{DCP3_CW{1'b0}}, bus.tlx_afu_dcp3_credit}
                    - (DCP3_CW+1)'(grantCost);
      vc3Cnt_d    = vc3Sum[VC3_CW] ? '1 : vc3Sum[VC3_CW-1:0];
      dcp3Cnt_d   = dcp3Sum[DCP3_CW] ? '1 : dcp3Sum[DCP3_CW-1:0];
      creditErr_d = creditErr_q || vc3Sum[VC3_CW] || dcp3Sum[DCP3_CW];
   end

   // Main FSM: credit load, command issue and flit sequencing, all outputs registered
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= INIT;
         rrPtr_q     <= 1'b0;
         sel_q       <= 1'b0;
         flitCnt_q   <= 3'd0;
         vc3Cnt_q    <= '0;
         dcp3Cnt_q   <= '0;
         creditErr_q <= 1'b0;
         vc3Valid_q  <= 1'b0;
         vc3Opcode_q <= 8'd0;
         vc3Afutag_q <= 16'd0;
         vc3Ea_q     <= 68'd0;
         vc3Dl_q     <= 2'd0;
         dcp3Valid_q <= 1'b0;
         dcp3Bus_q   <= 512'd0;
      end else begin
         vc3Valid_q  <= grant;
         dcp3Valid_q <= flitAccept;
         if (grant) begin
            vc3Opcode_q <= grantId ? bus.req1_opcode : bus.req0_opcode;
            vc3Afutag_q <= grantId ? bus.req1_afutag : bus.req0_afutag;
            vc3Ea_q     <= grantId ? bus.req1_ea     : bus.req0_ea;
            vc3Dl_q     <= grantId ? bus.req1_dl     : bus.req0_dl;
         end
         if (flitAccept) begin
            dcp3Bus_q <= selBus;
         end
         case (state_q)
            INIT: begin
               vc3Cnt_q  <= VC3_CW'(bus.tlx_afu_vc3_initial_credit);
               dcp3Cnt_q <= DCP3_CW'(bus.tlx_afu_dcp3_initial_credit);
               state_q   <= IDLE;
            end
            IDLE: begin
               vc3Cnt_q    <= vc3Cnt_d;
               dcp3Cnt_q   <= dcp3Cnt_d;
               creditErr_q <= creditErr_d;
               if (grant) begin
                  rrPtr_q <= ~grantId;
                  sel_q   <= grantId;
                  if (grantCost != 3'd0) begin
                     flitCnt_q <= grantCost;
                     state_q   <= DATA;
                  end
               end
            end
            DATA: begin
               vc3Cnt_q    <= vc3Cnt_d;
               dcp3Cnt_q   <= dcp3Cnt_d;
               creditErr_q <= creditErr_d;
               if (flitAccept) begin
                  flitCnt_q <= flitCnt_q - 3'd1;
                  if (flitCnt_q == 3'd1) begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= INIT;
         endcase
      end
   end

`ifdef OC4_VC3_ARB_STATS_EN
   logic [15:0] cmdCount0_q, cmdCount1_q;

   // Per-requester issued-command counters, wrapping at 16 bits
   always_ff @(posedge clock) begin
      if (reset) begin
         cmdCount0_q <= 16'd0;
         cmdCount1_q <= 16'd0;
      end else begin
         if (grant0) cmdCount0_q <= cmdCount0_q + 16'd1;
         if (grant1) cmdCount1_q <= cmdCount1_q + 16'd1;
      end
   end

   assign bus.req0_cmd_count = cmdCount0_q;
   assign bus.req1_cmd_count = cmdCount1_q;
`else
   assign bus.req0_cmd_count = 16'd0;
   assign bus.req1_cmd_count = 16'd0;
`endif

   assign bus.req0_ack                 = grant0;
   assign bus.req1_ack                 = grant1;
   assign bus.req0_data_ready          = ready0;
   assign bus.req1_data_ready          = ready1;
   assign bus.afu_tlx_vc3_valid        = vc3Valid_q;
   assign bus.afu_tlx_vc3_opcode       = vc3Opcode_q;
   assign bus.afu_tlx_vc3_afutag       = vc3Afutag_q;
   assign bus.afu_tlx_vc3_ea_ta_or_obj = vc3Ea_q;
   assign bus.afu_tlx_vc3_dl           = vc3Dl_q;
   assign bus.afu_tlx_dcp3_data_valid  = dcp3Valid_q;
   assign bus.afu_tlx_dcp3_data_bus    = dcp3Bus_q;
   assign bus.afu_tlx_dcp3_data_bdi    = 1'b0;
   assign bus.vc3_credit_cnt           = vc3Cnt_q;
   assign bus.dcp3_credit_cnt          = dcp3Cnt_q;
   assign bus.credit_err               = creditErr_q;

endmodule

// File: tb/tb_oc4_vc3_cmd_arb.sv
// tb_oc4_vc3_cmd_arb
// Directed bench for the VC3/DCP3 command arbiter: a vector table covers
// credit-limited issue and round-robin alternation, hand sequences cover the
// write-data, credit-saturation and mid-write reset corners.
`timescale 1ns/1ps
module tb_oc4_vc3_cmd_arb;

`ifdef OC4_VC3_ARB_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   typedef struct {
      logic        rst;
      logic [3:0]  vc3Init;
      logic [5:0]  dcp3Init;
      logic        r0v;
      logic        r1v;
      logic        vc3Ret;
      logic        expAck0;
      logic        expAck1;
      logic        expVc3Valid;
      logic [15:0] expTag;
      logic [3:0]  expVc3Cnt;
      logic [5:0]  expDcp3Cnt;
   } vec_t;

   logic clock;
   logic reset;
   int   compareCount;
   int   failCount;
   vec_t vecs[18];

   oc4_vc3_cmd_arb_if bus ();

   oc4_vc3_cmd_arb dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mk(input logic rst, input logic [3:0] vi, input logic [5:0] di,
                               input logic r0v, input logic r1v, input logic ret,
                               input logic a0, input logic a1, input logic vv,
                               input logic [15:0] tag, input logic [3:0] vc,
                               input logic [5:0] dc);
      vec_t v;
      v.rst = rst; v.vc3Init = vi; v.dcp3Init = di; v.r0v = r0v; v.r1v = r1v;
      v.vc3Ret = ret; v.expAck0 = a0; v.expAck1 = a1; v.expVc3Valid = vv;
      v.expTag = tag; v.expVc3Cnt = vc; v.expDcp3Cnt = dc;
      return v;
   endfunction

   function automatic logic [511:0] flit(input int k);
      logic [63:0] w;
      w = 64'hF117_0000_0000_0000 | 64'(k);
      return {8{w}};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compareCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkFlit(input string name, input int k);
      logic [511:0] expBus;
      expBus = flit(k);
      compareCount++;
      if (bus.afu_tlx_dcp3_data_bus !== expBus) begin
         failCount++;
         $display("[TB] FAIL %s: got low word 0x%0h, expected low word 0x%0h",
                  name, bus.afu_tlx_dcp3_data_bus[63:0], expBus[63:0]);
      end
   endtask

   task automatic clearInputs();
      bus.tlx_afu_vc3_credit  = 1'b0;
      bus.tlx_afu_dcp3_credit = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_opcode = 8'h00; bus.req0_afutag = 16'h0;
      bus.req0_ea = 68'h0;   bus.req0_dl = 2'b01;     bus.req0_wdata = 1'b0;
      bus.req0_data_valid = 1'b0; bus.req0_data_bus = 512'h0;
      bus.req1_valid = 1'b0; bus.req1_opcode = 8'h00; bus.req1_afutag = 16'h0;
      bus.req1_ea = 68'h0;   bus.req1_dl = 2'b01;     bus.req1_wdata = 1'b0;
      bus.req1_data_valid = 1'b0; bus.req1_data_bus = 512'h0;
   endtask

   // Leaves the bench one cycle after the INIT load, with the DUT in IDLE
   task automatic doReset(input logic [3:0] vi, input logic [5:0] di);
      clearInputs();
      bus.tlx_afu_vc3_initial_credit  = vi;
      bus.tlx_afu_dcp3_initial_credit = di;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      reset = v.rst;
      bus.tlx_afu_vc3_initial_credit  = v.vc3Init;
      bus.tlx_afu_dcp3_initial_credit = v.dcp3Init;
      bus.req0_valid = v.r0v;
      bus.req1_valid = v.r1v;
      bus.req0_afutag = 16'h1000 + 16'(idx);
      bus.req1_afutag = 16'h2000 + 16'(idx);
      bus.tlx_afu_vc3_credit = v.vc3Ret;
   endtask

   task automatic checkVector(input vec_t v, input int idx);
      checkOutput($sformatf("row%0d_ack0", idx), 64'(bus.req0_ack), 64'(v.expAck0));
      checkOutput($sformatf("row%0d_ack1", idx), 64'(bus.req1_ack), 64'(v.expAck1));
      checkOutput($sformatf("row%0d_vc3valid", idx), 64'(bus.afu_tlx_vc3_valid), 64'(v.expVc3Valid));
      checkOutput($sformatf("row%0d_vc3cnt", idx), 64'(bus.vc3_credit_cnt), 64'(v.expVc3Cnt));
      checkOutput($sformatf("row%0d_dcp3cnt", idx), 64'(bus.dcp3_credit_cnt), 64'(v.expDcp3Cnt));
      if (v.expVc3Valid) begin
         checkOutput($sformatf("row%0d_afutag", idx), 64'(bus.afu_tlx_vc3_afutag), 64'(v.expTag));
      end
   endtask

   initial begin
      compareCount = 0;
      failCount    = 0;

      //           rst vi  di  r0 r1 ret a0 a1 vv tag       vc  dc
      vecs[0]  = mk(1, 4,  8,  0, 0, 0,  0, 0, 0, 16'h0,    0,  0);
      vecs[1]  = mk(0, 4,  8,  1, 0, 0,  0, 0, 0, 16'h0,    0,  0);
      vecs[2]  = mk(0, 4,  8,  1, 0, 0,  1, 0, 0, 16'h0,    4,  8);
      vecs[3]  = mk(0, 4,  8,  1, 0, 0,  1, 0, 1, 16'h1002, 3,  8);
      vecs[4]  = mk(0, 4,  8,  1, 0, 0,  1, 0, 1, 16'h1003, 2,  8);
      vecs[5]  = mk(0, 4,  8,  1, 0, 0,  1, 0, 1, 16'h1004, 1,  8);
      vecs[6]  = mk(0, 4,  8,  1, 0, 0,  0, 0, 1, 16'h1005, 0,  8);
      vecs[7]  = mk(0, 4,  8,  1, 0, 1,  0, 0, 0, 16'h0,    0,  8);
      vecs[8]  = mk(0, 4,  8,  1, 0, 0,  1, 0, 0, 16'h0,    1,  8);
      vecs[9]  = mk(0, 4,  8,  0, 0, 0,  0, 0, 1, 16'h1008, 0,  8);
      vecs[10] = mk(1, 15, 63, 0, 0, 0,  0, 0, 0, 16'h0,    0,  8);
      vecs[11] = mk(0, 15, 63, 1, 1, 0,  0, 0, 0, 16'h0,    0,  0);
      vecs[12] = mk(0, 15, 63, 1, 1, 0,  1, 0, 0, 16'h0,    15, 63);
      vecs[13] = mk(0, 15, 63, 1, 1, 0,  0, 1, 1, 16'h100C, 14, 63);
      vecs[14] = mk(0, 15, 63, 1, 1, 0,  1, 0, 1, 16'h200D, 13, 63);
      vecs[15] = mk(0, 15, 63, 1, 1, 0,  0, 1, 1, 16'h100E, 12, 63);
      vecs[16] = mk(0, 15, 63, 0, 0, 0,  0, 0, 1, 16'h200F, 11, 63);
      vecs[17] = mk(0, 15, 63, 0, 0, 0,  0, 0, 0, 16'h0,    11, 63);

      clearInputs();
      bus.tlx_afu_vc3_initial_credit  = 4'd4;
      bus.tlx_afu_dcp3_initial_credit = 6'd8;
      reset = 1'b1;
      step();
      step();

      for (int i = 0; i < 18; i++) begin
         step();
         applyStimulus(vecs[i], i);
         #3;
         checkVector(vecs[i], i);
      end
      checkOutput("rr_cmdcount0", 64'(bus.req0_cmd_count), 64'(STATS * 2));
      checkOutput("rr_cmdcount1", 64'(bus.req1_cmd_count), 64'(STATS * 2));

      $display("[TB] simultaneous return/consume and saturation");
      doReset(4'd2, 6'd8);
      bus.req0_valid = 1'b1;
      bus.tlx_afu_vc3_credit = 1'b1;
      #3;
      checkOutput("simul_ack0", 64'(bus.req0_ack), 64'd1);
      step();
      bus.req0_valid = 1'b0;
      bus.tlx_afu_vc3_credit = 1'b0;
      #3;
      checkOutput("simul_net", 64'(bus.vc3_credit_cnt), 64'd2);
      checkOutput("simul_vc3valid", 64'(bus.afu_tlx_vc3_valid), 64'd1);

      doReset(4'd15, 6'd8);
      bus.tlx_afu_vc3_credit = 1'b1;
      #3;
      checkOutput("sat_errbefore", 64'(bus.credit_err), 64'd0);
      step();
      bus.tlx_afu_vc3_credit = 1'b0;
      #3;
      checkOutput("sat_cnt", 64'(bus.vc3_credit_cnt), 64'd15);
      checkOutput("sat_err", 64'(bus.credit_err), 64'd1);
      repeat (3) step();
      #3;
      checkOutput("sat_errsticky", 64'(bus.credit_err), 64'd1);
      doReset(4'd4, 6'd8);
      #3;
      checkOutput("sat_errclear", 64'(bus.credit_err), 64'd0);
      checkOutput("sat_reload", 64'(bus.vc3_credit_cnt), 64'd4);

      $display("[TB] dcp3-limited write does not block other requester");
      doReset(4'd8, 6'd3);
      bus.req0_valid = 1'b1; bus.req0_dl = 2'b11; bus.req0_wdata = 1'b1;
      bus.req0_opcode = 8'h81; bus.req0_afutag = 16'hA0A0;
      bus.req0_ea = 68'h1_2345_6789_ABCD_EF01;
      bus.req1_valid = 1'b1; bus.req1_dl = 2'b00; bus.req1_wdata = 1'b0;
      bus.req1_opcode = 8'h10; bus.req1_afutag = 16'hB1B1;
      #3;
      checkOutput("hol_ack0", 64'(bus.req0_ack), 64'd0);
      checkOutput("hol_ack1", 64'(bus.req1_ack), 64'd1);
      step();
      bus.req1_valid = 1'b0;
      bus.tlx_afu_dcp3_credit = 1'b1;
      #3;
      checkOutput("hol_held", 64'(bus.req0_ack), 64'd0);
      checkOutput("hol_tag1", 64'(bus.afu_tlx_vc3_afutag), 64'hB1B1);
      checkOutput("hol_dcp3", 64'(bus.dcp3_credit_cnt), 64'd3);
      step();
      bus.tlx_afu_dcp3_credit = 1'b0;
      #3;
      checkOutput("hol_dcp3ret", 64'(bus.dcp3_credit_cnt), 64'd4);
      checkOutput("hol_grant0", 64'(bus.req0_ack), 64'd1);
      step();
      bus.req0_valid = 1'b0;
      bus.req0_data_valid = 1'b1;
      bus.req0_data_bus = flit(0);
      #3;
      checkOutput("w4_vc3valid", 64'(bus.afu_tlx_vc3_valid), 64'd1);
      checkOutput("w4_tag", 64'(bus.afu_tlx_vc3_afutag), 64'hA0A0);
      checkOutput("w4_opcode", 64'(bus.afu_tlx_vc3_opcode), 64'h81);
      checkOutput("w4_dl", 64'(bus.afu_tlx_vc3_dl), 64'd3);
      checkOutput("w4_ealo", bus.afu_tlx_vc3_ea_ta_or_obj[63:0], 64'h2345_6789_ABCD_EF01);
      checkOutput("w4_eahi", 64'(bus.afu_tlx_vc3_ea_ta_or_obj[67:64]), 64'h1);
      checkOutput("w4_nodatayet", 64'(bus.afu_tlx_dcp3_data_valid), 64'd0);
      checkOutput("w4_dcp3zero", 64'(bus.dcp3_credit_cnt), 64'd0);
      checkOutput("w4_ready0", 64'(bus.req0_data_ready), 64'd1);
      for (int k = 1; k < 4; k++) begin
         step();
         bus.req0_data_bus = flit(k);
         #3;
         checkOutput($sformatf("w4_valid%0d", k - 1), 64'(bus.afu_tlx_dcp3_data_valid), 64'd1);
         checkFlit($sformatf("w4_flit%0d", k - 1), k - 1);
      end
      step();
      bus.req0_data_valid = 1'b0;
      #3;
      checkOutput("w4_valid3", 64'(bus.afu_tlx_dcp3_data_valid), 64'd1);
      checkFlit("w4_flit3", 3);
      checkOutput("w4_idleready", 64'(bus.req0_data_ready), 64'd0);
      checkOutput("w4_bdi", 64'(bus.afu_tlx_dcp3_data_bdi), 64'd0);
      step();
      #3;
      checkOutput("w4_done", 64'(bus.afu_tlx_dcp3_data_valid), 64'd0);

      $display("[TB] gapped write data");
      doReset(4'd8, 6'd8);
      bus.req0_valid = 1'b1; bus.req0_dl = 2'b10; bus.req0_wdata = 1'b1;
      bus.req0_afutag = 16'hC0C0;
      bus.req1_valid = 1'b1; bus.req1_afutag = 16'hD1D1;
      #3;
      checkOutput("gap_ack0", 64'(bus.req0_ack), 64'd1);
      checkOutput("gap_ack1", 64'(bus.req1_ack), 64'd0);
      step();
      bus.req0_valid = 1'b0;
      bus.req0_data_valid = 1'b1;
      bus.req0_data_bus = flit(10);
      #3;
      checkOutput("gap_ready0", 64'(bus.req0_data_ready), 64'd1);
      checkOutput("gap_ready1", 64'(bus.req1_data_ready), 64'd0);
      checkOutput("gap_nogrant", 64'(bus.req1_ack), 64'd0);
      checkOutput("gap_cmdfirst", 64'(bus.afu_tlx_dcp3_data_valid), 64'd0);
      checkOutput("gap_tag", 64'(bus.afu_tlx_vc3_afutag), 64'hC0C0);
      step();
      bus.req0_data_valid = 1'b0;
      #3;
      checkOutput("gap_valid0", 64'(bus.afu_tlx_dcp3_data_valid), 64'd1);
      checkFlit("gap_flit0", 10);
      checkOutput("gap_nogrant2", 64'(bus.req1_ack), 64'd0);
      step();
      #3;
      checkOutput("gap_hold", 64'(bus.afu_tlx_dcp3_data_valid), 64'd0);
      checkOutput("gap_stillready", 64'(bus.req0_data_ready), 64'd1);
      step();
      bus.req0_data_valid = 1'b1;
      bus.req0_data_bus = flit(11);
      #3;
      checkOutput("gap_hold2", 64'(bus.afu_tlx_dcp3_data_valid), 64'd0);
      step();
      bus.req0_data_valid = 1'b0;
      #3;
      checkOutput("gap_valid1", 64'(bus.afu_tlx_dcp3_data_valid), 64'd1);
      checkFlit("gap_flit1", 11);
      checkOutput("gap_idle", 64'(bus.req0_data_ready), 64'd0);
      checkOutput("gap_req1ack", 64'(bus.req1_ack), 64'd1);
      step();
      bus.req1_valid = 1'b0;
      #3;
      checkOutput("gap_req1tag", 64'(bus.afu_tlx_vc3_afutag), 64'hD1D1);
      checkOutput("gap_dcp3cnt", 64'(bus.dcp3_credit_cnt), 64'd6);
      checkOutput("gap_vc3cnt", 64'(bus.vc3_credit_cnt), 64'd6);

      $display("[TB] reset in the middle of a write");
      doReset(4'd8, 6'd8);
      bus.req0_valid = 1'b1; bus.req0_dl = 2'b11; bus.req0_wdata = 1'b1;
      bus.req0_afutag = 16'hE0E0;
      #3;
      checkOutput("rst_ack0", 64'(bus.req0_ack), 64'd1);
      step();
      bus.req0_valid = 1'b0;
      bus.req0_data_valid = 1'b1;
      bus.req0_data_bus = flit(20);
      #3;
      checkOutput("rst_ready0", 64'(bus.req0_data_ready), 64'd1);
      step();
      reset = 1'b1;
      bus.req0_data_bus = flit(21);
      #3;
      checkOutput("rst_flitout", 64'(bus.afu_tlx_dcp3_data_valid), 64'd1);
      checkFlit("rst_flit", 20);
      checkOutput("rst_cmdcount0pre", 64'(bus.req0_cmd_count), 64'(STATS));
      step();
      reset = 1'b0;
      #3;
      checkOutput("rst_vc3valid", 64'(bus.afu_tlx_vc3_valid), 64'd0);
      checkOutput("rst_dcp3valid", 64'(bus.afu_tlx_dcp3_data_valid), 64'd0);
      checkOutput("rst_dcp3bus", bus.afu_tlx_dcp3_data_bus[63:0], 64'd0);
      checkOutput("rst_vc3tag", 64'(bus.afu_tlx_vc3_afutag), 64'd0);
      checkOutput("rst_vc3cnt", 64'(bus.vc3_credit_cnt), 64'd0);
      checkOutput("rst_dcp3cnt", 64'(bus.dcp3_credit_cnt), 64'd0);
      checkOutput("rst_ready0", 64'(bus.req0_data_ready), 64'd0);
      checkOutput("rst_cmdcount0", 64'(bus.req0_cmd_count), 64'd0);
      step();
      #3;
      checkOutput("rst_vc3reload", 64'(bus.vc3_credit_cnt), 64'd8);
      checkOutput("rst_dcp3reload", 64'(bus.dcp3_credit_cnt), 64'd8);
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("rst_noflit%0d", k), 64'(bus.afu_tlx_dcp3_data_valid), 64'd0);
         checkOutput($sformatf("rst_noready%0d", k), 64'(bus.req0_data_ready), 64'd0);
         step();
         #3;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
